// File: rtl/downcounter_timer_if.sv
// Handshake bundle for the loadable down-counter / interval timer.
// Master drives the controls, slave returns count and status.
interface downcounter_timer_if #(
   parameter int WIDTH = 3
);
   logic             load;
   logic [WIDTH-1:0] d;
   logic             en;
   logic             mode;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             busy;

   modport master (
      output load, d, en, mode,
      input  q, tc, busy
   );

   modport slave (
      input  load, d, en, mode,
      output q, tc, busy
   );
endinterface

// File: rtl/downcounter_timer.sv
// Loadable down-counter with one-shot / auto-reload terminal-count pulse.
// All outputs are registered; rst is synchronous and active-high.
module downcounter_timer #(
   parameter int WIDTH = 3
) (
   input logic                clk,
   input logic                rst,
   downcounter_timer_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   state_t           state;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] rv;
   logic             tc;
   logic             busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= ZERO;
         rv    <= ZERO;
         tc    <= 1'b0;
         busy  <= 1'b0;
      end else if (bus.load) begin
         rv    <= bus.d;
         count <= bus.d;
         tc    <= 1'b0;
         if (bus.d != ZERO) begin
            state <= RUN;
            busy  <= 1'b1;
         end else begin
            state <= IDLE;
            busy  <= 1'b0;
         end
      end else begin
         tc <= 1'b0;
         if (state == RUN && bus.en) begin
            unique case (1'b1)
               (count > ONE): begin
                  count <= count - ONE;
               end
               (count == ONE): begin
                  count <= ZERO;
                  tc    <= 1'b1;
                  // mode only matters on the arrival at zero
                  if (!bus.mode) begin
                     state <= DONE;
                     busy  <= 1'b0;
                  end
               end
               default: begin
                  count <= rv;
               end
            endcase
         end
      end
   end

   assign bus.q    = count;
   assign bus.tc   = tc;
   assign bus.busy = busy;
endmodule

// File: tb/tb_downcounter_timer.sv
// Self-checking bench: directed vector table, corner sequences and
// randomized traffic against a behavioural model of the timer.
module tb_downcounter_timer;
   logic clk;
   logic rst;

   int checks   = 0;
   int failures = 0;

   downcounter_timer_if #(.WIDTH(3)) bus ();

   downcounter_timer #(.WIDTH(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural model: a running flag plus count and reload value
   bit       m_running = 0;
   bit [2:0] m_q       = 0;
   bit [2:0] m_rv      = 0;
   bit       m_tc      = 0;

   typedef struct {
      bit       r;
      bit       l;
      bit [2:0] d;
      bit       e;
      bit       m;
      bit [2:0] q;
      bit       tc;
      bit       busy;
   } vec_t;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit l, input bit [2:0] dv,
                             input bit e, input bit m);
      if (r) begin
         m_running = 0;
         m_q       = 0;
         m_rv      = 0;
         m_tc      = 0;
      end else if (l) begin
         m_rv      = dv;
         m_q       = dv;
         m_tc      = 0;
         m_running = (dv != 0);
      end else begin
         m_tc = 0;
         if (m_running && e) begin
            if (m_q == 0) begin
               m_q = m_rv;
            end else begin
               m_q = m_q - 1;
               if (m_q == 0) begin
                  m_tc = 1;
                  if (!m) m_running = 0;
               end
            end
         end
      end
   endtask

   task automatic cycle(input bit r, input bit l, input bit [2:0] dv,
                        input bit e, input bit m);
      rst      = r;
      bus.load = l;
      bus.d    = dv;
      bus.en   = e;
      bus.mode = m;
      @(posedge clk);
      model_step(r, l, dv, e, m);
      #1;
      chk("model_q", int'(bus.q), int'(m_q));
      chk("model_tc", int'(bus.tc), int'(m_tc));
      chk("model_busy", int'(bus.busy), int'(m_running));
   endtask

   vec_t vecs[$];

   task automatic add(input bit r, input bit l, input bit [2:0] dv,
                      input bit e, input bit m, input bit [2:0] q,
                      input bit t, input bit b);
      vec_t v;
      v.r = r; v.l = l; v.d = dv; v.e = e; v.m = m;
      v.q = q; v.tc = t; v.busy = b;
      vecs.push_back(v);
   endtask

   initial begin
      rst      = 1'b1;
      bus.load = 1'b0;
      bus.d    = '0;
      bus.en   = 1'b0;
      bus.mode = 1'b0;

      // reset
      add(1,0,0,0,0, 0,0,0);
      // one-shot load 5
      add(0,1,5,1,0, 5,0,1);
      add(0,0,0,1,0, 4,0,1);
      add(0,0,0,1,0, 3,0,1);
      add(0,0,0,1,0, 2,0,1);
      add(0,0,0,1,0, 1,0,1);
      add(0,0,0,1,0, 0,1,0);
      add(0,0,0,1,0, 0,0,0);
      add(0,0,0,1,0, 0,0,0);
      // auto-reload load 3
      add(0,1,3,1,1, 3,0,1);
      add(0,0,0,1,1, 2,0,1);
      add(0,0,0,1,1, 1,0,1);
      add(0,0,0,1,1, 0,1,1);
      add(0,0,0,1,1, 3,0,1);
      add(0,0,0,1,1, 2,0,1);
      add(0,0,0,1,1, 1,0,1);
      add(0,0,0,1,1, 0,1,1);
      add(0,0,0,1,1, 3,0,1);
      // enable gating at q=4
      add(0,1,6,1,0, 6,0,1);
      add(0,0,0,1,0, 5,0,1);
      add(0,0,0,1,0, 4,0,1);
      add(0,0,0,0,0, 4,0,1);
      add(0,0,0,0,0, 4,0,1);
      add(0,0,0,0,0, 4,0,1);
      add(0,0,0,1,0, 3,0,1);
      add(0,0,0,1,0, 2,0,1);
      // load beats en, then load 0
      add(0,1,7,1,0, 7,0,1);
      add(0,1,0,1,0, 0,0,0);
      add(0,0,0,1,0, 0,0,0);
      // load during tc cycle
      add(0,1,1,0,0, 1,0,1);
      add(0,0,0,1,0, 0,1,0);
      add(0,1,2,1,0, 2,0,1);
      // mode only sampled on the 1->0 edge
      add(0,1,2,0,1, 2,0,1);
      add(0,0,0,1,0, 1,0,1);
      add(0,0,0,1,1, 0,1,1);
      add(0,0,0,1,0, 2,0,1);
      // rst beats load
      add(1,1,5,1,1, 0,0,0);
      add(0,0,0,1,1, 0,0,0);

      foreach (vecs[i]) begin
         cycle(vecs[i].r, vecs[i].l, vecs[i].d, vecs[i].e, vecs[i].m);
         chk($sformatf("vec%0d_q", i), int'(bus.q), int'(vecs[i].q));
         chk($sformatf("vec%0d_tc", i), int'(bus.tc), int'(vecs[i].tc));
         chk($sformatf("vec%0d_busy", i), int'(bus.busy),
             int'(vecs[i].busy));
      end

      // reset mid-count, held for two edges, en ignored afterwards
      cycle(0,1,6,0,0);
      cycle(0,0,0,1,0);
      cycle(0,0,0,1,0);
      chk("rstmid_pre_q", int'(bus.q), 4);
      cycle(1,0,0,1,0);
      chk("rstmid_q", int'(bus.q), 0);
      chk("rstmid_tc", int'(bus.tc), 0);
      chk("rstmid_busy", int'(bus.busy), 0);
      cycle(1,0,0,1,0);
      repeat (3) cycle(0,0,0,1,0);
      chk("rstmid_idle_q", int'(bus.q), 0);
      chk("rstmid_idle_busy", int'(bus.busy), 0);

      // full range one-shot
      begin
         int n = 0;
         int tcs = 0;
         cycle(0,1,7,0,0);
         chk("full_load_q", int'(bus.q), 7);
         while (bus.q != 0 && n < 20) begin
            cycle(0,0,0,1,0);
            n++;
            tcs += int'(bus.tc);
         end
         chk("full_edges", n, 7);
         chk("full_tc_count", tcs, 1);
         tcs = 0;
         repeat (10) begin
            cycle(0,0,0,1,0);
            tcs += int'(bus.tc);
         end
         chk("full_extra_tc", tcs, 0);
         chk("full_hold_q", int'(bus.q), 0);
         chk("full_done_busy", int'(bus.busy), 0);
      end

      // full range auto-reload: reload on the 8th edge
      cycle(0,1,7,0,1);
      repeat (7) cycle(0,0,0,1,1);
      chk("auto7_q0", int'(bus.q), 0);
      chk("auto7_tc", int'(bus.tc), 1);
      cycle(0,0,0,1,1);
      chk("auto7_reload_q", int'(bus.q), 7);
      chk("auto7_busy", int'(bus.busy), 1);

      // randomized traffic against the model
      begin
         bit md = 0;
         for (int i = 0; i < 600; i++) begin
            bit r;
            bit l;
            bit e;
            bit [2:0] dv;
            r  = ($urandom_range(0, 59) == 0);
            l  = ($urandom_range(0, 11) == 0);
            e  = ($urandom_range(0, 3) != 0);
            dv = 3'($urandom);
            if ($urandom_range(0, 7) == 0) md = ~md;
            cycle(r, l, dv, e, md);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
